// File: rtl/ft600_pkg.sv
// Shared constants and helpers for the FT600 device-side emulator.
package ft600_pkg;

  // Default bus width and the byte-enable width that goes with it.
  localparam int FT_DATA_WIDTH_DEF = 32;
  localparam int BE_W              = FT_DATA_WIDTH_DEF / 8;

  // Error counters stop here instead of wrapping back to zero.
  localparam int ERR_CNT_MAX = 255;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ft600_emu_if.sv
// Control strobes, flags, host streams and status of the FT600 emulator.
// The bidirectional data/byte-enable lanes are separate module ports so
// that the tri-state drivers remain ordinary inout nets.
interface ft600_emu_if #(
  parameter int FT_DATA_WIDTH = 32
);
  localparam int BEW = FT_DATA_WIDTH / 8;

  // Bus control, driven by the FPGA-side master.
  logic                     ft_oe_n;
  logic                     ft_rd_n;
  logic                     ft_wr_n;
  // Bus flags, driven by the emulator.
  logic                     ft_txe_n;
  logic                     ft_rxf_n;
  // Host push into the read buffer.
  logic [FT_DATA_WIDTH-1:0] h_tx_data;
  logic [BEW-1:0]           h_tx_be;
  logic                     h_tx_valid;
  logic                     h_tx_ready;
  // Host pop from the write buffer.
  logic [FT_DATA_WIDTH-1:0] h_rx_data;
  logic [BEW-1:0]           h_rx_be;
  logic                     h_rx_valid;
  logic                     h_rx_ready;
  // Status.
  logic [7:0]               ovr_cnt;
  logic [7:0]               udr_cnt;
  logic                     error;

  // The emulator itself.
  modport slave (
    input  ft_oe_n, ft_rd_n, ft_wr_n,
    input  h_tx_data, h_tx_be, h_tx_valid, h_rx_ready,
    output ft_txe_n, ft_rxf_n,
    output h_tx_ready, h_rx_data, h_rx_be, h_rx_valid,
    output ovr_cnt, udr_cnt, error
  );

  // Whatever sits on the other side: FSM master plus host logic.
  modport master (
    output ft_oe_n, ft_rd_n, ft_wr_n,
    output h_tx_data, h_tx_be, h_tx_valid, h_rx_ready,
    input  ft_txe_n, ft_rxf_n,
    input  h_tx_ready, h_rx_data, h_rx_be, h_rx_valid,
    input  ovr_cnt, udr_cnt, error
  );

endinterface

// File: rtl/ft600_emu_buf.sv
// Register-array FIFO with a show-ahead head, occupancy count and the
// next-state count so callers can register flags without extra latency.
// DEPTH must be a power of two (pointers wrap by natural overflow).
module ft600_emu_buf
  import ft600_pkg::*;
#(
  parameter  int W     = 36,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_next_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // Never write past full or read past empty, whatever the caller does.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointers and count; reset discards contents by emptying the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset since the count gates them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/ft600_emu.sv
// Device-side FT600 245-synchronous FIFO emulator: answers an FPGA-side
// master on the bus and exposes both directions as host streams.
module ft600_emu
  import ft600_pkg::*;
#(
  parameter int FT_DATA_WIDTH = FT_DATA_WIDTH_DEF,
  parameter int DEPTH         = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  inout  wire  [FT_DATA_WIDTH-1:0]   ft_data,
  inout  wire  [FT_DATA_WIDTH/8-1:0] ft_be,
  ft600_emu_if.slave                 bus
);

  localparam int BEW = FT_DATA_WIDTH / 8;
  localparam int W   = FT_DATA_WIDTH + BEW;
  localparam int CW  = cnt_width(DEPTH);

  // Registered bus flags and drive enable.
  logic          txe_n_q;
  logic          rxf_n_q;
  logic          drv_q;
  // Status.
  logic [7:0]    ovr_q, ovr_d;
  logic [7:0]    udr_q, udr_d;
  logic          error_q, error_d;

  // Buffer hookups.
  logic [W-1:0]  rb_head, wb_head, rd_word;
  logic [CW-1:0] rb_count, rb_count_next, wb_count, wb_count_next;
  logic          rb_full, rb_empty, wb_full, wb_empty;
  logic          rb_push, rb_pop, wb_push, wb_pop;

  // Bus events for this edge.
  logic          wr_req, rd_req, overrun, underrun, contention;

  assign wr_req     = ~bus.ft_wr_n;
  assign rd_req     = ~bus.ft_rd_n;
  assign wb_push    = wr_req & ~txe_n_q;
  assign overrun    = wr_req & txe_n_q;
  assign rb_pop     = ~bus.ft_oe_n & rd_req & ~rxf_n_q;
  assign underrun   = rd_req & rxf_n_q;
  // Master strobes a write while we are still driving the lanes.
  assign contention = drv_q & wr_req;

  assign rb_push = bus.h_tx_valid & ~rb_full;
  assign wb_pop  = bus.h_rx_ready & ~wb_empty;

  // Host-to-master direction.
  ft600_emu_buf #(.W(W), .DEPTH(DEPTH)) u_rbuf (
    .clk          (clk),
    .reset        (reset),
    .push_i       (rb_push),
    .push_data_i  ({bus.h_tx_data, bus.h_tx_be}),
    .pop_i        (rb_pop),
    .head_o       (rb_head),
    .count_o      (rb_count),
    .count_next_o (rb_count_next),
    .full_o       (rb_full),
    .empty_o      (rb_empty)
  );

  // Master-to-host direction.
  ft600_emu_buf #(.W(W), .DEPTH(DEPTH)) u_wbuf (
    .clk          (clk),
    .reset        (reset),
    .push_i       (wb_push),
    .push_data_i  ({ft_data, ft_be}),
    .pop_i        (wb_pop),
    .head_o       (wb_head),
    .count_o      (wb_count),
    .count_next_o (wb_count_next),
    .full_o       (wb_full),
    .empty_o      (wb_empty)
  );

  // Raw counts and write-side full are only observed from outside.
  logic unused_status;
  assign unused_status = ^{rb_count, wb_count, wb_full};

  // Flags come from next-state counts so they are exact right after each
  // edge; drv follows oe_n with one cycle of turnaround.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txe_n_q <= 1'b1;
      rxf_n_q <= 1'b1;
      drv_q   <= 1'b0;
    end else begin
      txe_n_q <= (wb_count_next == CW'(DEPTH));
      rxf_n_q <= (rb_count_next == '0);
      drv_q   <= ~bus.ft_oe_n;
    end
  end

  // Saturating error counters and the sticky error flag.
  always_comb begin
    ovr_d   = ovr_q;
    udr_d   = udr_q;
    error_d = error_q;
    if (overrun && (ovr_q != 8'(ERR_CNT_MAX))) ovr_d = ovr_q + 8'd1;
    if (underrun && (udr_q != 8'(ERR_CNT_MAX))) udr_d = udr_q + 8'd1;
    if (overrun || underrun || contention) error_d = 1'b1;
  end

  // Status registers; cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_q   <= '0;
      udr_q   <= '0;
      error_q <= 1'b0;
    end else begin
      ovr_q   <= ovr_d;
      udr_q   <= udr_d;
      error_q <= error_d;
    end
  end

  // Lanes carry the read-buffer head, or zeros when there is nothing to read.
  assign rd_word = rb_empty ? '0 : rb_head;
  assign ft_data = drv_q ? rd_word[W-1:BEW] : {FT_DATA_WIDTH{1'bz}};
  assign ft_be   = drv_q ? rd_word[BEW-1:0] : {BEW{1'bz}};

  assign bus.ft_txe_n   = txe_n_q;
  assign bus.ft_rxf_n   = rxf_n_q;
  assign bus.h_tx_ready = ~rb_full;
  assign bus.h_rx_valid = ~wb_empty;
  assign bus.h_rx_data  = wb_head[W-1:BEW];
  assign bus.h_rx_be    = wb_head[BEW-1:0];
  assign bus.ovr_cnt    = ovr_q;
  assign bus.udr_cnt    = udr_q;
  assign bus.error      = error_q;

endmodule

// File: doc/ft600_emu.md
# ft600_emu

Synthesizable device-side emulator of the FT600 245-synchronous FIFO bus: the responder for the FPGA-side `ft600_fsm` master. It holds a host-to-FPGA read buffer and an FPGA-to-host write buffer, drives `txe_n`, `rxf_n` and the data/byte-enable lanes, and exposes both buffers to a host stream port. It is used for on-chip loopback and bring-up without the FT600 fitted, and as the bus responder in system benches.

## Interface
- `FT_DATA_WIDTH`, 32: bus width in bits; `ft_be` width is `FT_DATA_WIDTH/8`.
- `DEPTH`, 64: words per buffer; must be a power of 2, minimum 4.
- `clk` in 1: bus clock; the `ft_clk` seen by the master. Single clock domain.
- `reset` in 1: asynchronous, active-high.
- `ft_data` inout `FT_DATA_WIDTH`: bus data.
- `ft_be` inout `FT_DATA_WIDTH/8`: bus byte enables.
- `ft_oe_n` in 1: master output enable, active low.
- `ft_rd_n` in 1: master read strobe, active low.
- `ft_wr_n` in 1: master write strobe, active low.
- `ft_txe_n` out 1: low means the write buffer has space.
- `ft_rxf_n` out 1: low means the read buffer holds data.
- `h_tx_data` in `FT_DATA_WIDTH`, `h_tx_be` in `FT_DATA_WIDTH/8`, `h_tx_valid` in 1, `h_tx_ready` out 1: host push into the read buffer.
- `h_rx_data` out `FT_DATA_WIDTH`, `h_rx_be` out `FT_DATA_WIDTH/8`, `h_rx_valid` out 1, `h_rx_ready` in 1: host pop from the write buffer.
- `ovr_cnt` out 8: dropped writes, saturating.
- `udr_cnt` out 8: invalid read strobes, saturating.
- `error` out 1: sticky; set on any overrun, underrun or contention event.

## Operation
- Two instances of `ft600_emu_buf`, each holding data+be per entry:
  - **rbuf:** host pushes, master pops.
  - **wbuf:** master pushes, host pops.
- Each buffer has a count of width log2(DEPTH)+1. On the same edge, push and pop leave the count unchanged. Pointers wrap modulo DEPTH.
- **Master write:**
  - Accept when `ft_wr_n`=0 and registered `ft_txe_n`=0; capture `ft_data`/`ft_be` into wbuf.
  - If `ft_wr_n`=0 and `ft_txe_n`=1, drop the word, increment `ovr_cnt`, set `error`.
- **Master read:**
  - Bus drive enable `drv` <= ~`ft_oe_n`.
  - While `drv`=1, drive `ft_data`/`ft_be` with the rbuf head. If rbuf is empty, drive all zeros.
  - Pop when `ft_oe_n`=0, `ft_rd_n`=0 and `ft_rxf_n`=0.
  - If `ft_rd_n`=0 and `ft_rxf_n`=1, increment `udr_cnt` and set `error`.
- **Contention:** `drv`=1 and `ft_wr_n`=0 sets `error`. The write is still accepted if `ft_txe_n`=0.
- **Flags:**
  - `ft_txe_n` <= (wbuf count_next == DEPTH).
  - `ft_rxf_n` <= (rbuf count_next == 0).
  - Because both are registered from next-state, no word is accepted past full and no pop occurs past empty.
- **Host side:**
  - `h_tx_ready` = rbuf not full.
  - `h_rx_valid` = wbuf not empty.
  - `h_rx_data`/`h_rx_be` = wbuf head, show-ahead.
  - Transfer occurs on valid&ready at the edge.
- `ovr_cnt`/`udr_cnt` saturate at 255. Both counters and `error` clear only on reset.

## Timing
- **Reset values:**
  - `ft_txe_n`=1, `ft_rxf_n`=1, `drv`=0 (bus tri-stated).
  - Counts 0, `ovr_cnt`=0, `udr_cnt`=0, `error`=0.
  - `h_tx_ready`=1, `h_rx_valid`=0.
- **First cycle after reset deasserts:** `ft_txe_n` goes to 0 on the first edge.
- **Flag latency:**
  - Host push into empty rbuf at edge N: `ft_rxf_n`=0 after edge N.
  - Master pop of the last word at edge N: `ft_rxf_n`=1 after edge N.
- **Read latency:**
  - `ft_oe_n` falls before edge N: bus driven after edge N.
  - The first `ft_rd_n`-low edge pops the word currently on the bus; the next head appears the same cycle.
- **Write path:** no wait states; one word per cycle.
- **Reset mid-burst:** all buffer contents are discarded and the bus is released immediately (asynchronous).

## Structure
- Package `ft600_pkg`:
  - default `FT_DATA_WIDTH`
  - `BE_W` = `FT_DATA_WIDTH/8`
  - counter width function
  - `ERR_CNT_MAX` = 255
- Sub-module `ft600_emu_buf`:
  - register-array FIFO with show-ahead head, count, full/empty, next-count output
  - parameters `W` and `DEPTH`
- Top level: flag registers, `drv` register, tri-state assigns, error counters.

## Test plan
- **Host-to-master:** host pushes 0x11111111, 0x22222222, 0x33333333 (be=0xF); master reads with `oe_n` then `rd_n` held low 3 cycles. Expect 3 words in order, then `ft_rxf_n`=1 one edge after the third pop; `udr_cnt`=0.
- **Master-to-host:** master writes 0xA0000000..0xA0000009 back to back. Expect `h_rx_valid`=1 and host pops all 10 in order.
- **Write full:** DEPTH=4, host stalled, master writes 6 words. Expect `ft_txe_n`=1 after the 4th, words 5–6 dropped, `ovr_cnt`=2, `error`=1.
- **Simultaneous push/pop:** rbuf holds 2 words; on one edge the host pushes and the master pops. Expect count stays 2 and `ft_rxf_n` stays 0.
- **Invalid strobes:** `rd_n` low on empty rbuf for 3 cycles gives `udr_cnt`=3. `oe_n` low while `wr_n` low sets `error`=1.
- **Reset mid-burst:** assert `reset` during a 20-word master write. Expect bus tri-stated, both flags 1 and counts 0; after release, `ft_txe_n`=0 on the first edge.
